// File: rtl/mem_io_responder.sv
// Memory-side responder: decodes a 16-word I/O window on the CPU data bus,
// serving GPIO, switches, a prescaled compare timer and a TX byte FIFO.
module mem_io_responder #(
  parameter logic [15:0] IO_BASE        = 16'hC000,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMER_PRESCALE = 1000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] mem_addr,
  input  logic        Memwrite,
  input  logic [15:0] wr_data,
  input  logic [15:0] ram_rdata,
  output logic [15:0] cpu_rdata,
  output logic        ram_we,
  input  logic [15:0] sw_in,
  output logic [15:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PSW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;

  logic        w_hit;
  logic [3:0]  w_off;
  logic        w_we;
  logic        w_wr_gpio;
  logic        w_wr_cnt;
  logic        w_wr_cmp;
  logic        w_wr_ctl;
  logic        w_wr_stat;
  logic        w_wr_push;
  logic [15:0] w_io_rdata;

  logic [15:0] r_gpio;
  logic [15:0] r_sw_meta;
  logic [15:0] r_sw_sync;

  logic [PSW-1:0] r_presc;
  logic [15:0]    r_count;
  logic [15:0]    r_compare;
  logic           r_flag;
  logic           r_irq_en;
  logic           w_tick;
  logic           w_set;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_do_push;
  logic [3:0]    w_cnt4;

  assign w_hit = (mem_addr[15:4] == IO_BASE[15:4]);
  assign w_off = mem_addr[3:0];
  assign w_we  = Memwrite & w_hit;

  assign w_wr_gpio = w_we & (w_off == 4'd0);
  assign w_wr_cnt  = w_we & (w_off == 4'd2);
  assign w_wr_cmp  = w_we & (w_off == 4'd3);
  assign w_wr_ctl  = w_we & (w_off == 4'd4);
  assign w_wr_stat = w_we & (w_off == 4'd5);
  assign w_wr_push = w_we & (w_off == 4'd6);

  assign ram_we    = Memwrite & ~w_hit;
  assign cpu_rdata = w_hit ? w_io_rdata : ram_rdata;
  assign gpio_out  = r_gpio;
  assign timer_irq = r_flag & r_irq_en;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_gpio    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if (w_wr_gpio) r_gpio <= wr_data;
    end
  end

  assign w_tick = (r_presc == PSW'(TIMER_PRESCALE - 1));
  // A software count load beats a same-cycle tick and skips the compare.
  assign w_set  = w_tick & ~w_wr_cnt &
                  ((r_count + 16'd1) == r_compare);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_compare <= 16'hFFFF;
      r_flag    <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      if (w_wr_cnt) begin
        r_count <= wr_data;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= r_count + 16'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PSW'(1);
      end
      if (w_wr_cmp) r_compare <= wr_data;
      if (w_set) r_flag <= 1'b1;
      else if (w_wr_ctl & wr_data[0]) r_flag <= 1'b0;
      if (w_wr_ctl) r_irq_en <= wr_data[1];
    end
  end

  assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign tx_valid  = ~w_empty;
  assign tx_data   = r_mem[r_rp];
  assign w_pop     = tx_valid & tx_ready;
  assign w_do_push = w_wr_push & (~w_full | w_pop);
  assign w_cnt4    = 4'(r_cnt);

  always_ff @(posedge Clock) begin
    if (w_do_push) r_mem[r_wp] <= wr_data[7:0];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_do_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      if (w_do_push & ~w_pop) r_cnt <= r_cnt + CW'(1);
      else if (~w_do_push & w_pop) r_cnt <= r_cnt - CW'(1);
      if (w_wr_push & w_full & ~w_pop) r_ovf <= 1'b1;
      else if (w_wr_stat & wr_data[10]) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_io_rdata = '0;
    unique case (w_off)
      4'd0: w_io_rdata = r_gpio;
      4'd1: w_io_rdata = r_sw_sync;
      4'd2: w_io_rdata = r_count;
      4'd3: w_io_rdata = r_compare;
      4'd4: w_io_rdata = {14'd0, r_irq_en, r_flag};
      4'd5: w_io_rdata = {5'd0, r_ovf, w_full, w_empty, 4'd0, w_cnt4};
      default: w_io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder against a queue-based
// behavioural model of the I/O window.
module tb_mem_io_responder;

  localparam int P = 4;
  localparam int D = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] mem_addr;
  logic        Memwrite;
  logic [15:0] wr_data;
  logic [15:0] ram_rdata;
  logic [15:0] cpu_rdata;
  logic        ram_we;
  logic [15:0] sw_in;
  logic [15:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  mem_io_responder #(
    .IO_BASE(16'hC000),
    .FIFO_DEPTH(D),
    .TIMER_PRESCALE(P)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .mem_addr(mem_addr),
    .Memwrite(Memwrite),
    .wr_data(wr_data),
    .ram_rdata(ram_rdata),
    .cpu_rdata(cpu_rdata),
    .ram_we(ram_we),
    .sw_in(sw_in),
    .gpio_out(gpio_out),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .timer_irq(timer_irq)
  );

  int          m_presc;
  logic [15:0] m_gpio, m_count, m_cmp, m_s1, m_s2;
  bit          m_flag, m_irqen, m_ovf;
  logic [7:0]  m_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_presc = 0;
    m_gpio  = '0;
    m_count = '0;
    m_cmp   = 16'hFFFF;
    m_s1    = '0;
    m_s2    = '0;
    m_flag  = 0;
    m_irqen = 0;
    m_ovf   = 0;
    m_q.delete();
  endtask

  function automatic logic [15:0] m_io(input logic [3:0] off);
    int n;
    n = m_q.size();
    case (off)
      4'd0: return m_gpio;
      4'd1: return m_s2;
      4'd2: return m_count;
      4'd3: return m_cmp;
      4'd4: return {14'd0, m_irqen, m_flag};
      5: return {5'd0, m_ovf, n == D, n == 0, 4'd0, 4'(n)};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic step(input logic [15:0] a,
                      input bit we,
                      input logic [15:0] d);
    bit hit, w, pop, set, ovfset;
    logic [3:0] off;
    mem_addr  = a;
    Memwrite  = we;
    wr_data   = d;
    ram_rdata = 16'($urandom);
    #1;
    hit = (a[15:4] == 12'hC00);
    off = a[3:0];
    check("rdata", cpu_rdata, hit ? m_io(off) : ram_rdata);
    check("ram_we", ram_we, we & ~hit);
    check("gpio", gpio_out, m_gpio);
    check("tx_valid", tx_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
    check("irq", timer_irq, m_flag & m_irqen);
    @(posedge Clock);
    w   = we && hit;
    pop = (m_q.size() != 0) && tx_ready;
    set = 0;
    if (w && off == 2) begin
      m_count = d;
      m_presc = 0;
    end else if (m_presc == P - 1) begin
      m_presc = 0;
      m_count = m_count + 16'd1;
      if (m_count == m_cmp) set = 1;
    end else begin
      m_presc++;
    end
    if (set) m_flag = 1;
    else if (w && off == 4 && d[0]) m_flag = 0;
    if (w && off == 4) m_irqen = d[1];
    if (w && off == 3) m_cmp = d;
    if (w && off == 0) m_gpio = d;
    ovfset = 0;
    if (pop) void'(m_q.pop_front());
    if (w && off == 6) begin
      if (m_q.size() < D) m_q.push_back(d[7:0]);
      else ovfset = 1;
    end
    if (ovfset) m_ovf = 1;
    else if (w && off == 5 && d[10]) m_ovf = 0;
    m_s2 = m_s1;
    m_s1 = sw_in;
    @(negedge Clock);
  endtask

  initial begin
    int n;
    logic [3:0] off;
    logic [15:0] a, d;
    Reset    = 1'b0;
    mem_addr = '0;
    Memwrite = 1'b0;
    wr_data  = '0;
    ram_rdata = '0;
    sw_in    = '0;
    tx_ready = 1'b0;
    m_reset();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    step(16'hC000, 0, 0);
    step(16'hC003, 0, 0);
    step(16'hC005, 0, 0);

    step(16'hC000, 1, 16'h1234);
    check("gpio_1234", gpio_out, 16'h1234);
    step(16'h0100, 1, 16'hBEEF);
    step(16'h0100, 0, 0);

    step(16'hC003, 1, 16'd3);
    step(16'hC004, 1, 16'h0002);
    step(16'hC002, 1, 16'd0);
    n = 0;
    while (!timer_irq && n < 20) begin
      step(16'hC004, 0, 0);
      n++;
    end
    check("irq_latency", n, 12);
    step(16'hC004, 1, 16'h0003);
    step(16'hC004, 0, 0);

    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) step(16'hC006, 1, 16'(i * 16'h11));
    mem_addr = 16'hC005;
    #1;
    check("status_full", cpu_rdata, 16'h0604);
    check("head_first", tx_data, 8'h11);
    step(16'hC005, 1, 16'h0400);
    step(16'hC005, 0, 0);
    tx_ready = 1'b1;
    step(16'hC006, 1, 16'h0066);
    step(16'hC005, 0, 0);
    for (int i = 0; i < 5; i++) step(16'hC005, 0, 0);
    tx_ready = 1'b0;

    sw_in = 16'hA5A5;
    for (int i = 0; i < 3; i++) step(16'hC001, 0, 0);
    check("sw_sync", cpu_rdata, 16'hA5A5);
    step(16'hC009, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      tx_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
      off = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 2) a = 16'($urandom);
      else if ($urandom_range(0, 1) == 0) a = {12'hC00, 4'($urandom_range(0, 6))};
      else a = {12'hC00, off};
      if (a[3:0] == 4'd2 || a[3:0] == 4'd3) d = 16'($urandom_range(0, 15));
      else d = 16'($urandom);
      step(a, $urandom_range(0, 1) == 1, d);
    end

    tx_ready = 1'b0;
    step(16'hC005, 1, 16'h0400);
    for (int i = 0; i < 6; i++) step(16'hC005, 0, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(16'hC005, 0, 0);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(16'hC006, 1, 16'(8'hA0 + i));
    step(16'hC000, 1, 16'hFFFF);
    step(16'hC004, 1, 16'h0002);
    mem_addr = 16'hC005;
    Memwrite = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_gpio", gpio_out, 16'h0000);
    check("rst_irq", timer_irq, 1'b0);
    check("rst_status", cpu_rdata, 16'h0100);
    @(negedge Clock);
    Reset = 1'b1;
    m_reset();
    step(16'hC004, 0, 0);
    step(16'hC003, 0, 0);
    step(16'hC005, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
